// File: rtl/busqueda_instruccion.sv
// Instruction fetch stage: PC register, word-addressed instruction memory with a
// load port, and the IF/ID register that feeds the decode/execute datapath.
module busqueda_instruccion #(
  parameter int          ANCHO_DIR = 8,
  parameter logic [31:0] PC_RESET  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 parada,
  input  logic                 salto_en,
  input  logic [31:0]          salto_dir,
  input  logic                 carga_en,
  input  logic [ANCHO_DIR-1:0] carga_dir,
  input  logic [31:0]          carga_dato,
  output logic [31:0]          instruccion,
  output logic [31:0]          pc_sal,
  output logic [31:0]          pc_mas4,
  output logic                 valido,
  output logic [31:0]          pc_actual,
  output logic [31:0]          contador_instr
);

  localparam int          PROFUNDIDAD  = 2 ** ANCHO_DIR;
  localparam logic [31:0] PC_INICIAL   = {PC_RESET[31:2], 2'b00};

  logic [31:0] mem_q [PROFUNDIDAD];

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_sal_q, pc_sal_d;
  logic        valido_q, valido_d;
  logic [31:0] contador_q, contador_d;

  logic [ANCHO_DIR-1:0] indice;
  logic [31:0]          palabra_leida;
  logic [1:0]           unused_salto_bits;

  // Upper PC bits take no part in indexing, so addresses alias modulo the depth.
  assign indice            = pc_q[ANCHO_DIR+1:2];
  assign palabra_leida     = mem_q[indice];
  assign unused_salto_bits = salto_dir[1:0];

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_sal_d   = pc_sal_q;
    valido_d   = valido_q;
    contador_d = contador_q;
    if (salto_en) begin
      // The word fetched this cycle is squashed and replaced by a NOP bubble.
      pc_d     = {salto_dir[31:2], 2'b00};
      instr_d  = 32'h0000_0000;
      pc_sal_d = 32'h0000_0000;
      valido_d = 1'b0;
    end else if (!parada) begin
      instr_d    = palabra_leida;
      pc_sal_d   = pc_q;
      valido_d   = 1'b1;
      pc_d       = pc_q + 32'd4;
      contador_d = contador_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= PC_INICIAL;
      instr_q    <= 32'h0000_0000;
      pc_sal_q   <= 32'h0000_0000;
      valido_q   <= 1'b0;
      contador_q <= 32'h0000_0000;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_sal_q   <= pc_sal_d;
      valido_q   <= valido_d;
      contador_q <= contador_d;
    end
  end

  // Program image survives reset; a same-edge read of the written index sees the old word.
  always_ff @(posedge clk) begin
    if (carga_en) begin
      mem_q[carga_dir] <= carga_dato;
    end
  end

  assign instruccion    = instr_q;
  assign pc_sal         = pc_sal_q;
  assign pc_mas4        = pc_sal_q + 32'd4;
  assign valido         = valido_q;
  assign pc_actual      = pc_q;
  assign contador_instr = contador_q;

endmodule

// File: tb/tb_busqueda_instruccion.sv
// Self-checking bench for busqueda_instruccion: a reference model pushes expected
// IF/ID state into a scoreboard each cycle, and each scenario task pops and compares.
module tb_busqueda_instruccion;

  logic        clk;
  logic        rst;
  logic        parada;
  logic        salto_en;
  logic [31:0] salto_dir;
  logic        carga_en;
  logic [7:0]  carga_dir;
  logic [31:0] carga_dato;
  logic [31:0] instruccion;
  logic [31:0] pc_sal;
  logic [31:0] pc_mas4;
  logic        valido;
  logic [31:0] pc_actual;
  logic [31:0] contador_instr;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_sal;
    logic        valido;
    logic [31:0] pc_act;
    logic [31:0] cnt;
    logic [31:0] mas4;
  } obs_t;

  obs_t sb[$];

  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_cnt, m_instr, m_pcsal;
  logic        m_val;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] programa [8] = '{32'h012A4020, 32'h8D090004, 32'hAD090008, 32'h00000000,
                                32'h20080005, 32'h01095020, 32'h11400002, 32'h08000000};
  localparam logic [31:0] PALABRA_ULTIMA = 32'h3C01ABCD;

  busqueda_instruccion #(.ANCHO_DIR(8), .PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .parada(parada), .salto_en(salto_en), .salto_dir(salto_dir),
    .carga_en(carga_en), .carga_dir(carga_dir), .carga_dato(carga_dato),
    .instruccion(instruccion), .pc_sal(pc_sal), .pc_mas4(pc_mas4), .valido(valido),
    .pc_actual(pc_actual), .contador_instr(contador_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.instr  = instruccion;
    o.pc_sal = pc_sal;
    o.valido = valido;
    o.pc_act = pc_actual;
    o.cnt    = contador_instr;
    o.mas4   = pc_mas4;
    return o;
  endfunction

  // Drives one clock cycle, updates the reference model, pushes its expectation,
  // then returns 1 ns after the rising edge so outputs are settled.
  task automatic drive_cycle(input logic r, input logic par, input logic sj,
                             input logic [31:0] sd, input logic ce,
                             input logic [7:0] cd, input logic [31:0] cdat);
    rst = r; parada = par; salto_en = sj; salto_dir = sd;
    carga_en = ce; carga_dir = cd; carga_dato = cdat;
    if (r) begin
      m_instr = 32'h0; m_pcsal = 32'h0; m_val = 1'b0; m_pc = 32'h0; m_cnt = 32'h0;
    end else if (sj) begin
      m_pc = {sd[31:2], 2'b00}; m_instr = 32'h0; m_pcsal = 32'h0; m_val = 1'b0;
    end else if (!par) begin
      m_instr = m_mem[m_pc[9:2]]; m_pcsal = m_pc; m_val = 1'b1;
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end
    if (ce) m_mem[cd] = cdat;
    sb.push_back('{m_instr, m_pcsal, m_val, m_pc, m_cnt, m_pcsal + 32'd4});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t exp_o, got;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'(i), programa[i]);
      else       drive_cycle(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 8'hFF, PALABRA_ULTIMA);
      exp_o = sb.pop_front(); got = sample(); n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("[TB] FAIL reset step %0d: got %h, expected %h", i, got, exp_o);
      end
    end
    n_checks++;
    if (pc_mas4 !== 32'd4 || pc_actual !== 32'd0 || valido !== 1'b0 || instruccion !== 32'd0) begin
      n_errors++;
      $display("[TB] FAIL reset_values: got pc_mas4=%h pc=%h valido=%b instr=%h, expected 4/0/0/0",
               pc_mas4, pc_actual, valido, instruccion);
    end
  endtask

  task automatic test_fetch();
    obs_t exp_o, got;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
      exp_o = sb.pop_front(); got = sample(); n_checks++;
      if (got !== exp_o || instruccion !== programa[i] || pc_sal !== 32'(i * 4) || valido !== 1'b1) begin
        n_errors++;
        $display("[TB] FAIL fetch %0d: got %h, expected %h (instr %h pc_sal %h)",
                 i, got, exp_o, programa[i], 32'(i * 4));
      end
    end
    n_checks++;
    if (contador_instr !== 32'd4) begin
      n_errors++;
      $display("[TB] FAIL fetch_count: got %0d, expected 4", contador_instr);
    end
  endtask

  task automatic test_stall();
    obs_t exp_o, got;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    void'(sb.pop_front());
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
      exp_o = sb.pop_front(); got = sample(); n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("[TB] FAIL stall_pre %0d: got %h, expected %h", i, got, exp_o);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
      exp_o = sb.pop_front(); got = sample(); n_checks++;
      if (got !== exp_o || instruccion !== 32'h8D090004 || pc_sal !== 32'h4 || pc_actual !== 32'h8) begin
        n_errors++;
        $display("[TB] FAIL stall_hold %0d: got %h, expected %h", i, got, exp_o);
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    exp_o = sb.pop_front(); got = sample(); n_checks++;
    if (got !== exp_o || instruccion !== 32'hAD090008 || pc_sal !== 32'h8 || contador_instr !== 32'd3) begin
      n_errors++;
      $display("[TB] FAIL stall_release: got %h, expected %h", got, exp_o);
    end
  endtask

  task automatic test_redirect();
    obs_t exp_o, got;
    drive_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0013, 1'b0, 8'h0, 32'h0);
    exp_o = sb.pop_front(); got = sample(); n_checks++;
    if (got !== exp_o || valido !== 1'b0 || instruccion !== 32'h0 || pc_actual !== 32'h10) begin
      n_errors++;
      $display("[TB] FAIL redirect_bubble: got %h, expected %h", got, exp_o);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    exp_o = sb.pop_front(); got = sample(); n_checks++;
    if (got !== exp_o || instruccion !== 32'h20080005 || pc_sal !== 32'h10 || valido !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL redirect_target: got %h, expected %h", got, exp_o);
    end
  endtask

  task automatic test_wrap();
    obs_t exp_o, got;
    logic [31:0] exp_instr [4];
    exp_instr = '{PALABRA_ULTIMA, programa[0], programa[1], programa[2]};
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_03FC, 1'b0, 8'h0, 32'h0);
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
      exp_o = sb.pop_front(); got = sample(); n_checks++;
      if (got !== exp_o || pc_sal !== 32'h3FC + 32'(i * 4) || instruccion !== exp_instr[i] ||
          pc_mas4 !== 32'h400 + 32'(i * 4)) begin
        n_errors++;
        $display("[TB] FAIL wrap_alias %0d: got %h, expected %h", i, got, exp_o);
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 8'h0, 32'h0);
    exp_o = sb.pop_front(); got = sample(); n_checks++;
    if (got !== exp_o || pc_actual !== 32'hFFFF_FFFC) begin
      n_errors++;
      $display("[TB] FAIL wrap_redirect: got %h, expected %h", got, exp_o);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    exp_o = sb.pop_front(); got = sample(); n_checks++;
    if (got !== exp_o || pc_actual !== 32'h0 || pc_sal !== 32'hFFFF_FFFC || pc_mas4 !== 32'h0 ||
        instruccion !== PALABRA_ULTIMA) begin
      n_errors++;
      $display("[TB] FAIL wrap_pc: got %h, expected %h", got, exp_o);
    end
  endtask

  task automatic test_read_before_write();
    obs_t exp_o, got;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 8'h00, 32'hDEADBEEF);
    exp_o = sb.pop_front(); got = sample(); n_checks++;
    if (got !== exp_o || instruccion !== 32'h012A4020) begin
      n_errors++;
      $display("[TB] FAIL rbw_old: got %h, expected %h", got, exp_o);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 8'h0, 32'h0);
    void'(sb.pop_front());
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    exp_o = sb.pop_front(); got = sample(); n_checks++;
    if (got !== exp_o || instruccion !== 32'hDEADBEEF || pc_sal !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL rbw_new: got %h, expected %h", got, exp_o);
    end
  endtask

  task automatic test_reset_midrun();
    obs_t exp_o, got;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    void'(sb.pop_front());
    drive_cycle(1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 8'h0, 32'h0);
    exp_o = sb.pop_front(); got = sample(); n_checks++;
    if (got !== exp_o || pc_actual !== 32'h0 || valido !== 1'b0 || contador_instr !== 32'h0 ||
        pc_mas4 !== 32'h4 || instruccion !== 32'h0 || pc_sal !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL reset_midrun: got %h, expected %h", got, exp_o);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    exp_o = sb.pop_front(); got = sample(); n_checks++;
    if (got !== exp_o || instruccion !== 32'hDEADBEEF || contador_instr !== 32'd1 || valido !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL reset_mem_kept: got %h, expected %h", got, exp_o);
    end
  endtask

  initial begin
    rst = 1'b1; parada = 1'b0; salto_en = 1'b0; salto_dir = 32'h0;
    carga_en = 1'b0; carga_dir = 8'h0; carga_dato = 32'h0;
    m_pc = 32'h0; m_cnt = 32'h0; m_instr = 32'h0; m_pcsal = 32'h0; m_val = 1'b0;
    #2;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_wrap();
    test_read_before_write();
    test_reset_midrun();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
